master_split_stage: RTL and testbench

- Parametrised successor to the resizer's master output stage.
- Consumes packed output-buffer entries through a valid/ready handshake and drives an AXI-Stream style master port from a registered output stage.
- Splits any entry holding one or more packet boundaries into one beat per packet segment, so the m_keep_o lanes of a beat never straddle a boundary.
- Can left-align tail segments to lane 0. Counts completed packets.

---
 rtl/master_split_stage.sv | 151 +++++++++++++++
 tb/tb_master_split_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/master_split_stage.sv
// Registered AXI-Stream master stage: takes packed output-buffer entries and emits one beat per
// packet segment, so the keep lanes of a beat never straddle a packet boundary.
module master_split_stage #(
    parameter int T_DATA_WIDTH = 8,
    parameter int M_KEEP_WIDTH = 4,
    parameter int LANE_SZ      = 2 + T_DATA_WIDTH,
    parameter int ENTRY_SZ     = LANE_SZ * M_KEEP_WIDTH,
    parameter int LEFT_ALIGN   = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ENTRY_SZ-1:0]                entry_i,
    input  logic                               entry_valid_i,
    output logic                               entry_ready_o,
    output logic                               m_valid_o,
    input  logic                               m_ready_i,
    output logic                               m_last_o,
    output logic [M_KEEP_WIDTH-1:0]            m_keep_o,
    output logic [T_DATA_WIDTH*M_KEEP_WIDTH-1:0] m_data_o,
    output logic [CNT_WIDTH-1:0]               pkt_count_o
);

    // state | meaning
    // IDLE  | no entry held; a valid entry_i is the segment source
    // SPLIT | entry held in held_q, rem_q marks lanes still to be emitted (never zero)
    typedef enum logic {IDLE, SPLIT} state_t;

    localparam int LO_W = (M_KEEP_WIDTH > 1) ? $clog2(M_KEEP_WIDTH) : 1;
    localparam int DW   = T_DATA_WIDTH * M_KEEP_WIDTH;

    state_t                  state_q, state_d;
    logic [ENTRY_SZ-1:0]     held_q, held_d;
    logic [M_KEEP_WIDTH-1:0] rem_q, rem_d;

    logic                    out_free;
    logic                    has_src;
    logic [ENTRY_SZ-1:0]     src_entry;
    logic [M_KEEP_WIDTH-1:0] src_rem;
    logic [M_KEEP_WIDTH-1:0] lane_keep, lane_last;
    logic [DW-1:0]           lane_data;
    logic [M_KEEP_WIDTH-1:0] seg;
    logic [LO_W-1:0]         lo;
    logic                    found_lo;
    logic                    beat_last;
    logic [M_KEEP_WIDTH-1:0] beat_keep;
    logic [DW-1:0]           beat_data;
    logic                    beat_emit;
    logic [M_KEEP_WIDTH-1:0] rem_next;
    logic                    leading;

    assign out_free      = !m_valid_o || m_ready_i;
    assign has_src       = (state_q == SPLIT) || entry_valid_i;
    assign entry_ready_o = (state_q == IDLE) && out_free;

    always_comb begin
        src_entry = (state_q == SPLIT) ? held_q : entry_i;
        src_rem   = (state_q == SPLIT) ? rem_q : '1;

        lane_keep = '0;
        lane_last = '0;
        lane_data = '0;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
            lane_keep[i] = src_entry[i*LANE_SZ];
            lane_last[i] = src_entry[i*LANE_SZ+1];
            lane_data[i*T_DATA_WIDTH +: T_DATA_WIDTH] = src_entry[i*LANE_SZ+2 +: T_DATA_WIDTH];
        end

        // Segment: from the lowest remaining lane up to and including the first last lane.
        seg       = '0;
        lo        = '0;
        found_lo  = 1'b0;
        beat_last = 1'b0;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
            if (src_rem[i] && !beat_last) begin
                seg[i] = 1'b1;
                if (!found_lo) begin
                    found_lo = 1'b1;
                    lo       = i[LO_W-1:0];
                end
                if (lane_last[i]) beat_last = 1'b1;
            end
        end

        beat_keep = lane_keep & seg;
        beat_data = '0;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
            if (seg[i]) beat_data[i*T_DATA_WIDTH +: T_DATA_WIDTH] = lane_data[i*T_DATA_WIDTH +: T_DATA_WIDTH];
        end
        if (LEFT_ALIGN != 0) begin
            beat_keep = beat_keep >> lo;
            beat_data = beat_data >> (int'(lo) * T_DATA_WIDTH);
        end
        beat_emit = (|beat_keep) || beat_last;

        // Null lanes at the bottom of the remainder would only produce empty beats; drop them now.
        rem_next = src_rem & ~seg;
        leading  = 1'b1;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
            if (rem_next[i] && leading) begin
                if (!lane_keep[i] && !lane_last[i]) rem_next[i] = 1'b0;
                else                                leading     = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        rem_d   = rem_q;
        if (out_free && has_src) begin
            if (rem_next == '0) begin
                state_d = IDLE;
                rem_d   = '0;
            end else begin
                state_d = SPLIT;
                rem_d   = rem_next;
                if (state_q == IDLE) held_d = entry_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            held_q      <= '0;
            rem_q       <= '0;
            m_valid_o   <= 1'b0;
            m_last_o    <= 1'b0;
            m_keep_o    <= '0;
            m_data_o    <= '0;
            pkt_count_o <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            rem_q   <= rem_d;
            if (m_valid_o && m_ready_i && m_last_o) pkt_count_o <= pkt_count_o + 1'b1;
            if (out_free) begin
                if (has_src) begin
                    m_valid_o <= beat_emit;
                    m_last_o  <= beat_last;
                    m_keep_o  <= beat_keep;
                    m_data_o  <= beat_data;
                end else begin
                    m_valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_master_split_stage.sv
// Directed bench for master_split_stage: one instance with lanes in place, one left-aligned,
// both driven from the same stimulus.
module tb_master_split_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] entry_i = '0;
    logic        entry_valid_i = 1'b0;
    logic        m_ready_i = 1'b1;

    logic        entry_ready_o, m_valid_o, m_last_o;
    logic [3:0]  m_keep_o;
    logic [31:0] m_data_o;
    logic [15:0] pkt_count_o;

    logic        la_entry_ready_o, la_m_valid_o, la_m_last_o;
    logic [3:0]  la_m_keep_o;
    logic [31:0] la_m_data_o;
    logic [15:0] la_pkt_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    master_split_stage #(.T_DATA_WIDTH(8), .M_KEEP_WIDTH(4), .LEFT_ALIGN(0), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .entry_i(entry_i), .entry_valid_i(entry_valid_i),
        .entry_ready_o(entry_ready_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_last_o(m_last_o), .m_keep_o(m_keep_o), .m_data_o(m_data_o), .pkt_count_o(pkt_count_o)
    );

    master_split_stage #(.T_DATA_WIDTH(8), .M_KEEP_WIDTH(4), .LEFT_ALIGN(1), .CNT_WIDTH(16)) u_dut_la (
        .clk(clk), .rst(rst), .entry_i(entry_i), .entry_valid_i(entry_valid_i),
        .entry_ready_o(la_entry_ready_o), .m_valid_o(la_m_valid_o), .m_ready_i(m_ready_i),
        .m_last_o(la_m_last_o), .m_keep_o(la_m_keep_o), .m_data_o(la_m_data_o),
        .pkt_count_o(la_pkt_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] make_entry(input logic [3:0] keep, input logic [3:0] last,
                                               input logic [31:0] data);
        logic [39:0] e;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            e[i*10]          = keep[i];
            e[i*10+1]        = last[i];
            e[i*10+2 +: 8]   = data[i*8 +: 8];
        end
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        entry_valid_i = 1'b0;
        m_ready_i = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [3:0] keep, input logic last,
                              input logic [31:0] data);
        check({tag, ".valid"}, m_valid_o, 1'b1);
        check({tag, ".keep"},  m_keep_o,  keep);
        check({tag, ".last"},  m_last_o,  last);
        check({tag, ".data"},  m_data_o,  data);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst.valid", m_valid_o, 1'b0);
        check("rst.last",  m_last_o, 1'b0);
        check("rst.keep",  m_keep_o, 4'b0000);
        check("rst.data",  m_data_o, 32'h0);
        check("rst.count", pkt_count_o, 16'd0);

        // 1: full entry, no boundary
        entry_i = make_entry(4'b1111, 4'b0000, 32'h44332211);
        entry_valid_i = 1'b1;
        #1;
        check("t1.ready", entry_ready_o, 1'b1);
        step();
        entry_valid_i = 1'b0;
        check_beat("t1.beat", 4'b1111, 1'b0, 32'h44332211);
        check("t1.count", pkt_count_o, 16'd0);
        step();
        check("t1.idle", m_valid_o, 1'b0);
        check("t1.count2", pkt_count_o, 16'd0);

        // 2: boundary on lane 1
        do_reset();
        entry_i = make_entry(4'b1111, 4'b0010, 32'h44332211);
        entry_valid_i = 1'b1;
        step();
        entry_valid_i = 1'b0;
        #1;
        check_beat("t2.b1", 4'b0011, 1'b1, 32'h00002211);
        check("t2.ready_split", entry_ready_o, 1'b0);
        step();
        check_beat("t2.b2", 4'b1100, 1'b0, 32'h44330000);
        check("t2.count", pkt_count_o, 16'd1);
        check("t2.ready_idle", entry_ready_o, 1'b1);
        step();
        check("t2.idle", m_valid_o, 1'b0);
        check("t2.count2", pkt_count_o, 16'd1);

        // 3: boundaries on lanes 0 and 3, left-aligned instance
        do_reset();
        entry_i = make_entry(4'b1111, 4'b1001, 32'h44332211);
        entry_valid_i = 1'b1;
        step();
        entry_valid_i = 1'b0;
        check("t3.la.b1.valid", la_m_valid_o, 1'b1);
        check("t3.la.b1.keep",  la_m_keep_o, 4'b0001);
        check("t3.la.b1.last",  la_m_last_o, 1'b1);
        check("t3.la.b1.data",  la_m_data_o, 32'h00000011);
        step();
        check("t3.la.b2.valid", la_m_valid_o, 1'b1);
        check("t3.la.b2.keep",  la_m_keep_o, 4'b0111);
        check("t3.la.b2.last",  la_m_last_o, 1'b1);
        check("t3.la.b2.data",  la_m_data_o, 32'h00443322);
        check_beat("t3.na.b2", 4'b1110, 1'b1, 32'h44332200);
        step();
        check("t3.la.count", la_pkt_count_o, 16'd2);
        check("t3.la.idle",  la_m_valid_o, 1'b0);

        // 4: back-pressure while the split is pending
        do_reset();
        entry_i = make_entry(4'b1111, 4'b0010, 32'h44332211);
        entry_valid_i = 1'b1;
        step();
        entry_i = make_entry(4'b0001, 4'b0001, 32'h000000AA);
        m_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_beat($sformatf("t4.hold%0d", c), 4'b0011, 1'b1, 32'h00002211);
            check($sformatf("t4.ready%0d", c), entry_ready_o, 1'b0);
            step();
        end
        check_beat("t4.hold3", 4'b0011, 1'b1, 32'h00002211);
        check("t4.count_stall", pkt_count_o, 16'd0);
        m_ready_i = 1'b1;
        #1;
        check("t4.ready_split", entry_ready_o, 1'b0);
        step();
        check_beat("t4.b2", 4'b1100, 1'b0, 32'h44330000);
        check("t4.count", pkt_count_o, 16'd1);
        step();
        entry_valid_i = 1'b0;
        check_beat("t4.next", 4'b0001, 1'b1, 32'h000000AA);
        step();
        check("t4.idle", m_valid_o, 1'b0);
        check("t4.count2", pkt_count_o, 16'd2);

        // 5: all-null entry consumed silently, then a one-lane packet
        do_reset();
        entry_i = make_entry(4'b0000, 4'b0000, 32'h0);
        entry_valid_i = 1'b1;
        #1;
        check("t5.ready", entry_ready_o, 1'b1);
        step();
        check("t5.null", m_valid_o, 1'b0);
        entry_i = make_entry(4'b0001, 4'b0001, 32'h0000005A);
        #1;
        check("t5.ready2", entry_ready_o, 1'b1);
        step();
        entry_valid_i = 1'b0;
        check_beat("t5.beat", 4'b0001, 1'b1, 32'h0000005A);
        step();
        check("t5.idle", m_valid_o, 1'b0);
        check("t5.count", pkt_count_o, 16'd1);

        // 6: reset in the middle of a split drops the tail
        do_reset();
        entry_i = make_entry(4'b1111, 4'b0010, 32'h44332211);
        entry_valid_i = 1'b1;
        step();
        entry_valid_i = 1'b0;
        check_beat("t6.b1", 4'b0011, 1'b1, 32'h00002211);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6.rst.valid", m_valid_o, 1'b0);
        check("t6.rst.count", pkt_count_o, 16'd0);
        step();
        check("t6.no_b2", m_valid_o, 1'b0);
        check("t6.count", pkt_count_o, 16'd0);
        entry_i = make_entry(4'b0011, 4'b0010, 32'h0000BEEF);
        entry_valid_i = 1'b1;
        step();
        entry_valid_i = 1'b0;
        check_beat("t6.next", 4'b0011, 1'b1, 32'h0000BEEF);
        step();
        check("t6.idle", m_valid_o, 1'b0);
        check("t6.count2", pkt_count_o, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
